pc_fetch_unit: RTL and testbench

Program counter and instruction-fetch stage for the 14-bit-instruction core. It drives the program ROM address every cycle and latches the returned 14-bit word into an instruction register (IR) for the decoder. It implements the 8-level hardware return stack and pipeline flushes on control transfers. The decoder/ALU stage downstream selects the next-PC operation each cycle through `pc_op`.

---
 rtl/pc_fetch_pkg.sv | 20 ++
 rtl/return_stack.sv | 61 ++++++
 rtl/pc_fetch_unit.sv | 113 +++++++++++
 tb/tb_pc_fetch_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the program-counter / fetch stage.
package pc_fetch_pkg;

    localparam int PC_ADDR_W = 11;
    localparam int INSTR_W   = 14;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 14'h0000;

    // Next-PC operation selected by the decode stage; code 7 behaves as HOLD.
    typedef enum logic [2:0] {
        PC_HOLD   = 3'd0,
        PC_INC    = 3'd1,
        PC_GOTO   = 3'd2,
        PC_CALL   = 3'd3,
        PC_RETURN = 3'd4,
        PC_SKIP   = 3'd5,
        PC_LOAD   = 3'd6
    } pc_op_t;

endpackage

// File: rtl/return_stack.sv
// Circular hardware return stack with sticky overflow/underflow flags.
// Overflow overwrites the oldest entry; underflow still moves the pointer
// and exposes whatever stale entry sits below it.
module return_stack #(
    parameter int DEPTH   = 8,
    parameter int DATA_W  = 11,
    parameter int PTR_W   = $clog2(DEPTH),
    parameter int DEPTH_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic [DATA_W-1:0]  i_push_data,
    output logic [DATA_W-1:0]  o_top,
    output logic [DEPTH_W-1:0] o_depth,
    output logic               o_overflow,
    output logic               o_underflow
);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]   r_sp;
    logic [DEPTH_W-1:0] r_depth;
    logic               r_overflow;
    logic               r_underflow;
    logic               w_full;
    logic               w_empty;

    assign w_full  = (r_depth == DEPTH_W'(DEPTH));
    assign w_empty = (r_depth == '0);

    // Top of stack is the entry just below the pointer; a pop returns it.
    assign o_top       = r_mem[r_sp - PTR_W'(1)];
    assign o_depth     = r_depth;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

    // Entry storage is deliberately not reset; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_sp] <= i_push_data;
    end

    // Pointer, occupancy and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp        <= '0;
            r_depth     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (i_push) begin
            r_sp <= r_sp + PTR_W'(1);
            if (w_full) r_overflow <= 1'b1;
            else        r_depth    <= r_depth + DEPTH_W'(1);
        end else if (i_pop) begin
            r_sp <= r_sp - PTR_W'(1);
            if (w_empty) r_underflow <= 1'b1;
            else         r_depth     <= r_depth - DEPTH_W'(1);
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch: drives the ROM address from PC,
// latches the returned word into IR and flushes IR on every control transfer.
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter int                ADDR_W       = PC_ADDR_W,
    parameter int                STACK_DEPTH  = 8,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  pc_op_t                       pc_op,
    input  logic [ADDR_W-1:0]            k_addr,
    input  logic [ADDR_W-1:0]            pc_load_value,
    input  logic [INSTR_W-1:0]           Rom_data_in,
    output logic [ADDR_W-1:0]            Rom_addr_out,
    output logic [INSTR_W-1:0]           ir_out,
    output logic                         ir_valid,
    output logic [$clog2(STACK_DEPTH):0] stack_depth,
    output logic                         stack_overflow,
    output logic                         stack_underflow
);

    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic               r_ir_valid;

    logic [ADDR_W-1:0]  w_pc_next;
    logic [INSTR_W-1:0] w_ir_next;
    logic               w_valid_next;
    logic               w_push;
    logic               w_pop;
    logic [ADDR_W-1:0]  w_top;

    // ROM address comes straight from the PC register, never from pc_op.
    assign Rom_addr_out = r_pc;
    assign ir_out       = r_ir;
    assign ir_valid     = r_ir_valid;

    // PC already points past the CALL when it executes, so PC itself is the return address.
    return_stack #(
        .DEPTH  (STACK_DEPTH),
        .DATA_W (ADDR_W)
    ) u_stack (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (r_pc),
        .o_top       (w_top),
        .o_depth     (stack_depth),
        .o_overflow  (stack_overflow),
        .o_underflow (stack_underflow)
    );

    // Next-PC / IR selection; every transfer replaces the fetched word with a NOP bubble.
    always_comb begin
        w_pc_next    = r_pc;
        w_ir_next    = r_ir;
        w_valid_next = r_ir_valid;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        case (pc_op)
            PC_INC: begin
                w_pc_next    = r_pc + ADDR_W'(1);
                w_ir_next    = Rom_data_in;
                w_valid_next = 1'b1;
            end
            PC_GOTO: begin
                w_pc_next    = k_addr;
                w_ir_next    = NOP_INSTR;
                w_valid_next = 1'b0;
            end
            PC_CALL: begin
                w_push       = 1'b1;
                w_pc_next    = k_addr;
                w_ir_next    = NOP_INSTR;
                w_valid_next = 1'b0;
            end
            PC_RETURN: begin
                w_pop        = 1'b1;
                w_pc_next    = w_top;
                w_ir_next    = NOP_INSTR;
                w_valid_next = 1'b0;
            end
            PC_SKIP: begin
                w_pc_next    = r_pc + ADDR_W'(1);
                w_ir_next    = NOP_INSTR;
                w_valid_next = 1'b0;
            end
            PC_LOAD: begin
                w_pc_next    = pc_load_value;
                w_ir_next    = NOP_INSTR;
                w_valid_next = 1'b0;
            end
            default: ;
        endcase
    end

    // PC, IR and valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_VECTOR;
            r_ir       <= NOP_INSTR;
            r_ir_valid <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_ir       <= w_ir_next;
            r_ir_valid <= w_valid_next;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a combinational ROM model.
module tb_pc_fetch_unit;
    import pc_fetch_pkg::*;

    logic         clk;
    logic         rst_n;
    pc_op_t       pc_op;
    logic [10:0]  k_addr;
    logic [10:0]  pc_load_value;
    logic [13:0]  Rom_data_in;
    logic [10:0]  Rom_addr_out;
    logic [13:0]  ir_out;
    logic         ir_valid;
    logic [3:0]   stack_depth;
    logic         stack_overflow;
    logic         stack_underflow;

    logic [13:0]  rom [2048];
    int           checks;
    int           errors;

    pc_fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_op           (pc_op),
        .k_addr          (k_addr),
        .pc_load_value   (pc_load_value),
        .Rom_data_in     (Rom_data_in),
        .Rom_addr_out    (Rom_addr_out),
        .ir_out          (ir_out),
        .ir_valid        (ir_valid),
        .stack_depth     (stack_depth),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow)
    );

    assign Rom_data_in = rom[Rom_addr_out];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one op, clock one edge, settle just after the edge.
    task automatic step(input pc_op_t op, input logic [10:0] k, input logic [10:0] ld);
        pc_op         = op;
        k_addr        = k;
        pc_load_value = ld;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        // Default ROM word = 0x2000 + address; a few locations carry specific words.
        for (int a = 0; a < 2048; a++) rom[a] = 14'h2000 + 14'(a);
        rom[0]  = 14'h3005;
        rom[1]  = 14'h00A5;
        rom[2]  = 14'h3003;
        rom[7]  = 14'h0823;
        rom[12] = 14'h3200;

        rst_n = 1'b0;
        pc_op = PC_HOLD;
        k_addr = '0;
        pc_load_value = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", 32'(Rom_addr_out), 32'h000);
        chk("rst_ir", 32'(ir_out), 32'h0000);
        chk("rst_valid", 32'(ir_valid), 32'd0);
        chk("rst_depth", 32'(stack_depth), 32'd0);
        chk("rst_flags", {30'd0, stack_overflow, stack_underflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Sequential fetch
        step(PC_INC, 0, 0);
        chk("inc1_pc", 32'(Rom_addr_out), 32'h001);
        chk("inc1_ir", 32'(ir_out), 32'h3005);
        chk("inc1_valid", 32'(ir_valid), 32'd1);
        step(PC_INC, 0, 0);
        chk("inc2_pc", 32'(Rom_addr_out), 32'h002);
        chk("inc2_ir", 32'(ir_out), 32'h00A5);
        step(PC_INC, 0, 0);
        chk("inc3_pc", 32'(Rom_addr_out), 32'h003);
        chk("inc3_ir", 32'(ir_out), 32'h3003);
        chk("inc3_valid", 32'(ir_valid), 32'd1);

        // GOTO
        step(PC_GOTO, 11'h007, 0);
        chk("goto_pc", 32'(Rom_addr_out), 32'h007);
        chk("goto_ir", 32'(ir_out), 32'h0000);
        chk("goto_valid", 32'(ir_valid), 32'd0);
        step(PC_INC, 0, 0);
        chk("goto_inc_ir", 32'(ir_out), 32'h0823);
        chk("goto_inc_valid", 32'(ir_valid), 32'd1);
        step(PC_INC, 0, 0);
        chk("pre_call_pc", 32'(Rom_addr_out), 32'h009);

        // CALL / RETURN
        step(PC_CALL, 11'h100, 0);
        chk("call_pc", 32'(Rom_addr_out), 32'h100);
        chk("call_depth", 32'(stack_depth), 32'd1);
        chk("call_valid", 32'(ir_valid), 32'd0);
        step(PC_INC, 0, 0);
        step(PC_INC, 0, 0);
        chk("sub_pc", 32'(Rom_addr_out), 32'h102);
        chk("sub_ir", 32'(ir_out), 32'h2101);
        step(PC_RETURN, 0, 0);
        chk("ret_pc", 32'(Rom_addr_out), 32'h009);
        chk("ret_depth", 32'(stack_depth), 32'd0);
        chk("ret_valid", 32'(ir_valid), 32'd0);
        chk("ret_ir", 32'(ir_out), 32'h0000);

        // SKIP
        step(PC_INC, 0, 0);
        step(PC_INC, 0, 0);
        chk("pre_skip_pc", 32'(Rom_addr_out), 32'h00B);
        step(PC_SKIP, 0, 0);
        chk("skip_pc", 32'(Rom_addr_out), 32'h00C);
        chk("skip_ir", 32'(ir_out), 32'h0000);
        chk("skip_valid", 32'(ir_valid), 32'd0);
        step(PC_INC, 0, 0);
        chk("skip_inc_ir", 32'(ir_out), 32'h3200);

        // HOLD and the unused code 7
        step(PC_HOLD, 11'h155, 11'h2AA);
        chk("hold_pc", 32'(Rom_addr_out), 32'h00D);
        chk("hold_ir", 32'(ir_out), 32'h3200);
        step(pc_op_t'(3'd7), 11'h155, 11'h2AA);
        chk("op7_pc", 32'(Rom_addr_out), 32'h00D);
        chk("op7_valid", 32'(ir_valid), 32'd1);

        // LOAD and wrap-around
        step(PC_LOAD, 0, 11'h7FF);
        chk("load_pc", 32'(Rom_addr_out), 32'h7FF);
        chk("load_valid", 32'(ir_valid), 32'd0);
        step(PC_INC, 0, 0);
        chk("wrap_pc0", 32'(Rom_addr_out), 32'h000);
        chk("wrap_ir", 32'(ir_out), 32'h27FF);
        step(PC_INC, 0, 0);
        chk("wrap_pc1", 32'(Rom_addr_out), 32'h001);

        // Nine CALLs: return addresses pushed are 0x001, 0x010 .. 0x017
        for (int i = 0; i < 9; i++) begin
            step(PC_CALL, 11'(16 + i), 0);
            chk("ovf_depth", 32'(stack_depth), 32'((i < 8) ? i + 1 : 8));
            chk("ovf_flag", 32'(stack_overflow), 32'((i == 8) ? 1 : 0));
        end
        chk("ovf_pc", 32'(Rom_addr_out), 32'h018);

        // Eight RETURNs newest first, then an underflowing ninth
        for (int j = 0; j < 8; j++) begin
            step(PC_RETURN, 0, 0);
            chk("pop_pc", 32'(Rom_addr_out), 32'(11'h017 - 11'(j)));
            chk("pop_depth", 32'(stack_depth), 32'(7 - j));
            chk("pop_unf", 32'(stack_underflow), 32'd0);
        end
        step(PC_RETURN, 0, 0);
        chk("unf_pc", 32'(Rom_addr_out), 32'h017);
        chk("unf_depth", 32'(stack_depth), 32'd0);
        chk("unf_flag", 32'(stack_underflow), 32'd1);

        // Flags are sticky until reset
        step(PC_INC, 0, 0);
        step(PC_CALL, 11'h040, 0);
        chk("sticky_ovf", 32'(stack_overflow), 32'd1);
        chk("sticky_unf", 32'(stack_underflow), 32'd1);
        chk("sticky_depth", 32'(stack_depth), 32'd1);

        // Asynchronous reset mid-cycle
        rst_n = 1'b0;
        #1;
        chk("arst_pc", 32'(Rom_addr_out), 32'h000);
        chk("arst_flags", {30'd0, stack_overflow, stack_underflow}, 32'd0);
        chk("arst_depth", 32'(stack_depth), 32'd0);
        chk("arst_valid", 32'(ir_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
